operand_serializer: RTL and testbench
=====================================

OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 reset  input  1  Synchronous, active-low reset; sampled on the rising clk edge.
REQ-004 load_valid  input  1  Producer presents an operand pair.
REQ-005 load_ready  output  1  Block accepts an operand pair this cycle.
REQ-006 op_a  input  WIDTH  Operand A, parallel.
REQ-007 op_b  input  WIDTH  Operand B, parallel.
REQ-008 abort  input  1  Cancel the operation in progress.
REQ-009 adder_clear  output  1  One-cycle active-high pulse that clears the downstream serial adder carry.
REQ-010 data_out1  output  1  Serial bit of A, LSB first (drives the adder's data_in1).
REQ-011 data_out2  output  1  Serial bit of B, LSB first (drives the adder's data_in2).
REQ-012 shift_control  output  1  High exactly while a valid bit pair is on data_out1/data_out2.
REQ-013 busy  output  1  High in any state other than IDLE.
REQ-014 done  output  1  One-cycle pulse after the last bit pair.

Function
REQ-015 The FSM SHALL have four states: IDLE, CLEAR, SHIFT and DONE.
REQ-016 IDLE: load_ready=1; a handshake (load_valid & load_ready) SHALL capture op_a/op_b into internal registers and move the FSM to CLEAR.
REQ-017 CLEAR: adder_clear=1 for exactly one cycle, the bit counter loads 0, then SHIFT.
REQ-018 SHIFT: shift_control=1; data_out1/data_out2 = LSB of the A/B registers; each cycle both registers shift right by 1 (zero fill) and the counter increments.
REQ-019 SHIFT SHALL last exactly WIDTH cycles; the counter width is clog2(WIDTH+1); on count==WIDTH-1 the FSM goes to DONE.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 Latency: accept at edge k gives adder_clear in cycle k+1, bits i=0..WIDTH-1 in cycles k+2+i, done in cycle k+WIDTH+2, and load_ready again in cycle k+WIDTH+3.
REQ-022 Outside SHIFT, data_out1, data_out2 and shift_control SHALL be 0.
REQ-023 load_ready=0 outside IDLE; load_valid outside IDLE SHALL be ignored and the captured operands SHALL NOT change.
REQ-024 abort in CLEAR, SHIFT or DONE SHALL return the FSM to IDLE on the next edge with no done pulse; abort in IDLE has no effect.
REQ-025 If abort is asserted in the last SHIFT cycle, abort wins: the FSM goes to IDLE and done is not pulsed.
REQ-026 WIDTH=1 SHALL produce exactly one SHIFT cycle.
REQ-027 Back-to-back operands SHALL be accepted only after the return to IDLE; there is no overlap of operations.

Reset
REQ-028 While reset=0 at a clk edge, the FSM SHALL go to IDLE and the counter and operand registers SHALL clear to 0.
REQ-029 Reset output values: load_ready=1 after release; busy, done, adder_clear, shift_control, data_out1 and data_out2 all 0.
REQ-030 Reset mid-operation SHALL discard the operation, with no done pulse and no further shift_control.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, CLEAR, SHIFT, DONE) and the default WIDTH constant.
REQ-032 One sub-module, piso_shift_reg (parallel load, shift right, LSB out), SHALL be instantiated twice, once for A and once for B.
REQ-033 The FSM and counter SHALL be in the top module; all outputs SHALL decode from registered state.

Verification
REQ-034 WIDTH=8, A=0x5D, B=0x3B -> data_out1 = 1,0,1,1,1,0,1,0 and data_out2 = 1,1,0,1,1,1,0,0 over 8 shift_control cycles; done at cycle k+10.
REQ-035 Adder chained downstream, A=0xFF, B=0x01 -> serial sum 0x00 with final cout=1; adder_clear precedes the first bit by 1 cycle.
REQ-036 load_valid held high continuously -> next pair accepted exactly WIDTH+3 cycles after the previous accept; operands changing mid-shift have no effect.
REQ-037 abort in SHIFT cycle 3 -> IDLE next cycle, shift_control drops, no done, load_ready=1.
REQ-038 reset=0 in SHIFT cycle 5 -> all outputs 0 next edge; after release a new load runs a full sequence correctly.
REQ-039 WIDTH=1, A=1, B=1 -> a single shift cycle with data_out1=1 and data_out2=1; done 3 cycles after accept.

Source files
------------

// File: rtl/operand_serializer_pkg.sv
// Operand serializer shared types.
// State encoding and default operand width.
package operand_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register.
// Loads a word, shifts right with zero fill, LSB out.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next word: load has priority over shift.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = data_q >> 1;
    end
  end

  // Register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign lsb = data_q[0];

endmodule

// File: rtl/operand_serializer.sv
// Operand serializer top: FSM, bit counter
// and two PISO registers feeding a serial adder.
module operand_serializer
  import operand_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             adder_clear,
  output logic             data_out1,
  output logic             data_out2,
  output logic             shift_control,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;
  logic          in_shift;
  logic          a_lsb;
  logic          b_lsb;

  assign accept   = (state_q == IDLE) && load_valid;
  assign in_shift = (state_q == SHIFT);

  // Next-state and counter logic; abort beats the last-bit exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sr_a (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (in_shift),
    .din   (op_a),
    .lsb   (a_lsb)
  );

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sr_b (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (in_shift),
    .din   (op_b),
    .lsb   (b_lsb)
  );

  assign load_ready    = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign adder_clear   = (state_q == CLEAR);
  assign shift_control = in_shift;
  assign done          = (state_q == DONE);
  assign data_out1     = in_shift & a_lsb;
  assign data_out2     = in_shift & b_lsb;

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer.
// Cycle model derived from accept-relative timing.
module tb_operand_serializer;

  localparam int W = 8;

  logic clk;
  logic reset;

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         abort;
  logic         adder_clear;
  logic         data_out1;
  logic         data_out2;
  logic         shift_control;
  logic         busy;
  logic         done;

  logic l1_valid;
  logic l1_ready;
  logic [0:0] l1_a;
  logic [0:0] l1_b;
  logic l1_abort;
  logic l1_clr;
  logic l1_d1;
  logic l1_d2;
  logic l1_sc;
  logic l1_busy;
  logic l1_done;

  int total;
  int bad;

  operand_serializer #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .abort         (abort),
    .adder_clear   (adder_clear),
    .data_out1     (data_out1),
    .data_out2     (data_out2),
    .shift_control (shift_control),
    .busy          (busy),
    .done          (done)
  );

  operand_serializer #(.WIDTH(1)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (l1_valid),
    .load_ready    (l1_ready),
    .op_a          (l1_a),
    .op_b          (l1_b),
    .abort         (l1_abort),
    .adder_clear   (l1_clr),
    .data_out1     (l1_d1),
    .data_out2     (l1_d2),
    .shift_control (l1_sc),
    .busy          (l1_busy),
    .done          (l1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ready,busy,clr,sc,d1,d2,done} at t cycles after accept.
  function automatic logic [6:0] model(
    input int t, input logic [31:0] a,
    input logic [31:0] b, input int w);
    if (t == 1) return 7'b0110000;
    if (t >= 2 && t <= w + 1)
      return {3'b010, 1'b1, a[t-2], b[t-2], 1'b0};
    if (t == w + 2) return 7'b0100001;
    return 7'b1000000;
  endfunction

  function automatic logic [6:0] obs8();
    return {load_ready, busy, adder_clear, shift_control,
            data_out1, data_out2, done};
  endfunction

  function automatic logic [6:0] obs1();
    return {l1_ready, l1_busy, l1_clr, l1_sc,
            l1_d1, l1_d2, l1_done};
  endfunction

  task automatic test_reset();
    logic [6:0] o;
    reset = 1'b0;
    load_valid = 1'b1;
    op_a = 8'hAA;
    op_b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs8();
      total++;
      if (o !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_hold got=%b exp=%b", o, 7'b1000000);
      end
    end
    load_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = obs8();
      total++;
      if (o !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_release got=%b exp=%b", o, 7'b1000000);
      end
      o = obs1();
      total++;
      if (o !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_w1 got=%b exp=%b", o, 7'b1000000);
      end
    end
  endtask

  task automatic test_vector(input logic [W-1:0] a,
                             input logic [W-1:0] b);
    logic [6:0] o, e;
    logic [W-1:0] sum;
    logic cy;
    int k, clr_t, first_t;
    sum = '0;
    cy = 1'b0;
    k = 0;
    clr_t = -1;
    first_t = -1;
    load_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 1; t <= W + 3; t++) begin
      @(negedge clk);
      if (t == 1) load_valid = 1'b0;
      op_a = W'($urandom);
      op_b = W'($urandom);
      o = obs8();
      e = model(t, 32'(a), 32'(b), W);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL vec a=%h b=%h t=%0d got=%b exp=%b",
                 a, b, t, o, e);
      end
      if (adder_clear) begin
        cy = 1'b0;
        if (clr_t < 0) clr_t = t;
      end
      if (shift_control && k < W) begin
        if (first_t < 0) first_t = t;
        sum[k] = data_out1 ^ data_out2 ^ cy;
        cy = (data_out1 & data_out2) | (cy & (data_out1 ^ data_out2));
        k++;
      end
    end
    total++;
    if ({cy, sum} !== (9'(a) + 9'(b))) begin
      bad++;
      $display("FAIL adder_sum a=%h b=%h got=%h exp=%h",
               a, b, {cy, sum}, 9'(a) + 9'(b));
    end
    total++;
    if (first_t - clr_t !== 1) begin
      bad++;
      $display("FAIL clear_lead got=%0d exp=1", first_t - clr_t);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      test_vector(W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] o, e;
    logic [W-1:0] acc_a, acc_b;
    int acc_t;
    load_valid = 1'b1;
    op_a = W'($urandom);
    op_b = W'($urandom);
    acc_a = op_a;
    acc_b = op_b;
    acc_t = 0;
    for (int c = 1; c <= 3 * (W + 3); c++) begin
      @(negedge clk);
      o = obs8();
      e = model(c - acc_t, 32'(acc_a), 32'(acc_b), W);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, o, e);
      end
      op_a = W'($urandom);
      op_b = W'($urandom);
      if (load_ready) begin
        total++;
        if (c - acc_t !== W + 3) begin
          bad++;
          $display("FAIL b2b_gap got=%0d exp=%0d",
                   c - acc_t, W + 3);
        end
        acc_t = c;
        acc_a = op_a;
        acc_b = op_b;
      end
    end
    load_valid = 1'b0;
    repeat (W + 4) @(negedge clk);
  endtask

  task automatic test_abort(input int at_t, input string nm);
    logic [6:0] o, e;
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    load_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 1; t <= at_t; t++) begin
      @(negedge clk);
      load_valid = 1'b0;
      o = obs8();
      e = model(t, 32'(a), 32'(b), W);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s t=%0d got=%b exp=%b", nm, t, o, e);
      end
    end
    abort = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      abort = 1'b0;
      o = obs8();
      total++;
      if (o !== 7'b1000000) begin
        bad++;
        $display("FAIL %s_after t=%0d got=%b exp=%b",
                 nm, t, o, 7'b1000000);
      end
    end
  endtask

  task automatic test_abort_idle();
    logic [6:0] o, e;
    logic [W-1:0] a, b;
    a = 8'hC3;
    b = 8'h3C;
    load_valid = 1'b1;
    abort = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 1; t <= W + 3; t++) begin
      @(negedge clk);
      load_valid = 1'b0;
      abort = 1'b0;
      o = obs8();
      e = model(t, 32'(a), 32'(b), W);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort_idle t=%0d got=%b exp=%b", t, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o, e;
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    load_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      load_valid = 1'b0;
      o = obs8();
      e = model(t, 32'(a), 32'(b), W);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rst_mid t=%0d got=%b exp=%b", t, o, e);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    o = obs8();
    total++;
    if (o !== 7'b1000000) begin
      bad++;
      $display("FAIL rst_mid_clear got=%b exp=%b", o, 7'b1000000);
    end
    reset = 1'b1;
    @(negedge clk);
    o = obs8();
    total++;
    if (o !== 7'b1000000) begin
      bad++;
      $display("FAIL rst_mid_idle got=%b exp=%b", o, 7'b1000000);
    end
    test_vector(W'($urandom), W'($urandom));
  endtask

  task automatic test_width1();
    logic [6:0] o, e;
    logic [0:0] a, b;
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 1'b1 : 1'($urandom);
      b = (n == 0) ? 1'b1 : 1'($urandom);
      l1_valid = 1'b1;
      l1_a = a;
      l1_b = b;
      for (int t = 1; t <= 4; t++) begin
        @(negedge clk);
        l1_valid = 1'b0;
        l1_a = 1'($urandom);
        l1_b = 1'($urandom);
        o = obs1();
        e = model(t, 32'(a), 32'(b), 1);
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL w1 a=%b b=%b t=%0d got=%b exp=%b",
                   a, b, t, o, e);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    load_valid = 1'b0;
    abort = 1'b0;
    op_a = '0;
    op_b = '0;
    l1_valid = 1'b0;
    l1_abort = 1'b0;
    l1_a = '0;
    l1_b = '0;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_vector(8'h5D, 8'h3B);
    test_vector(8'hFF, 8'h01);
    test_random();
    test_back_to_back();
    test_abort(4, "abort_sh3");
    test_abort(W + 1, "abort_last");
    test_abort(1, "abort_clr");
    test_abort_idle();
    test_reset_mid();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
